// File: rtl/mon_tx_scheduler.sv
// -----------------------------------------------------------------------------
// mon_tx_scheduler
//   Schedules every device-to-NeXT packet onto the single serial Sender.
//   Three event sources (power-on, audio sample request, keyboard/mouse data)
//   are latched or queued so that simultaneous events are never lost. An
//   arbiter then presents one 40-bit packet at a time with a valid/ready
//   handshake.
//
//   Priority is power-on > audio > keyboard. Keyboard still wins over audio
//   once MAX_STREAK audio packets have been granted in a row while keyboard
//   data was waiting, so a steady stream of audio requests cannot starve
//   keyboard and mouse traffic.
//
// Ports
//   mon_clk       in   1   monitor-link clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   power_on_req  in   1   1-cycle pulse: power-on event
//   audio_req     in   1   1-cycle pulse: request next audio sample
//   kbd_valid     in   1   1-cycle pulse: kbd_data/kbd_is_mouse valid
//   kbd_is_mouse  in   1   1 = mouse event, 0 = key event
//   kbd_data      in   16  keyboard/mouse payload
//   pkt_ready     in   1   Sender accepts a packet this cycle
//   pkt_valid     out  1   pkt_data holds a packet awaiting acceptance
//   pkt_data      out  40  packet, MSB transmitted first
//   kbd_overflow  out  1   1-cycle pulse: keyboard event dropped (FIFO full)
//   drop_cnt      out  8   saturating count of dropped keyboard events
// -----------------------------------------------------------------------------
module mon_tx_scheduler #(
    parameter int          KBD_DEPTH      = 4,
    parameter int          KBD_AW         = 2,
    parameter int          MAX_STREAK     = 3,
    parameter logic [39:0] POWER_ON_CODE  = 40'hC000000000,
    parameter logic [39:0] AUDIO_REQ_CODE = 40'hC700000000
) (
    input  logic        mon_clk,
    input  logic        rst_n,
    input  logic        power_on_req,
    input  logic        audio_req,
    input  logic        kbd_valid,
    input  logic        kbd_is_mouse,
    input  logic [15:0] kbd_data,
    input  logic        pkt_ready,
    output logic        pkt_valid,
    output logic [39:0] pkt_data,
    output logic        kbd_overflow,
    output logic [7:0]  drop_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    localparam logic [1:0] WIN_PWR = 2'd0;
    localparam logic [1:0] WIN_AUD = 2'd1;
    localparam logic [1:0] WIN_KBD = 2'd2;

    localparam int                SW         = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [KBD_AW:0]   FIFO_FULL  = (KBD_AW + 1)'(KBD_DEPTH);
    localparam logic [KBD_AW:0]   CNT_ONE    = (KBD_AW + 1)'(1);
    localparam logic [KBD_AW-1:0] PTR_ONE    = KBD_AW'(1);

    logic [0:0]        r_state;
    logic [1:0]        r_winner;
    logic              r_pend_pwr;
    logic              r_pend_aud;
    logic [16:0]       r_fifo_mem [KBD_DEPTH];
    logic [KBD_AW-1:0] r_wr_ptr;
    logic [KBD_AW-1:0] r_rd_ptr;
    logic [KBD_AW:0]   r_count;
    logic [SW-1:0]     r_streak;
    logic              r_pkt_valid;
    logic [39:0]       r_pkt_data;
    logic              r_kbd_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_accept;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [16:0]       w_kbd_head;
    logic [39:0]       w_kbd_pkt;
    logic              w_grant;
    logic [1:0]        w_win;
    logic [39:0]       w_pkt;

    // In OFFER pkt_valid is always high, so the state alone qualifies the handshake.
    assign w_accept     = (r_state == ST_OFFER) && pkt_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == FIFO_FULL);
    assign w_pop        = w_accept && (r_winner == WIN_KBD);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_push       = kbd_valid && (!w_fifo_full || w_pop);
    assign w_drop       = kbd_valid && w_fifo_full && !w_pop;

    assign w_kbd_head   = r_fifo_mem[r_rd_ptr];
    assign w_kbd_pkt    = {7'b1100010, w_kbd_head[16], 8'h00, w_kbd_head[15:0], 8'h00};

    // Arbitration is only evaluated in IDLE; a winner in OFFER is never replaced.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_grant = 1'b0;
        w_win   = WIN_PWR;
        w_pkt   = POWER_ON_CODE;
        if (r_state == ST_IDLE) begin
            if (r_pend_pwr) begin
                w_grant = 1'b1;
                w_win   = WIN_PWR;
                w_pkt   = POWER_ON_CODE;
            end else if (r_pend_aud && !((r_streak == STREAK_MAX) && !w_fifo_empty)) begin
                w_grant = 1'b1;
                w_win   = WIN_AUD;
                w_pkt   = AUDIO_REQ_CODE;
            end else if (!w_fifo_empty) begin
                w_grant = 1'b1;
                w_win   = WIN_KBD;
                w_pkt   = w_kbd_pkt;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge mon_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {kbd_is_mouse, kbd_data};
        end
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state        <= ST_IDLE;
            r_winner       <= WIN_PWR;
            r_pend_pwr     <= 1'b0;
            r_pend_aud     <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_streak       <= '0;
            r_pkt_valid    <= 1'b0;
            r_pkt_data     <= '0;
            r_kbd_overflow <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            // A request on the accept edge re-arms its flag: set beats clear.
            r_pend_pwr <= power_on_req || (r_pend_pwr && !(w_accept && (r_winner == WIN_PWR)));
            r_pend_aud <= audio_req    || (r_pend_aud && !(w_accept && (r_winner == WIN_AUD)));

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: ;
            endcase

            r_kbd_overflow <= w_drop;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            // The streak only matters while keyboard data waits, so an empty FIFO resets it.
            if (w_fifo_empty) begin
                r_streak <= '0;
            end else if (w_grant && (w_win == WIN_KBD)) begin
                r_streak <= '0;
            end else if (w_grant && (w_win == WIN_AUD) && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + SW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state     <= ST_OFFER;
                        r_winner    <= w_win;
                        r_pkt_valid <= 1'b1;
                        r_pkt_data  <= w_pkt;
                    end
                end
                default: begin
                    if (pkt_ready) begin
                        r_state     <= ST_IDLE;
                        r_pkt_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pkt_valid    = r_pkt_valid;
    assign pkt_data     = r_pkt_data;
    assign kbd_overflow = r_kbd_overflow;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_mon_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mon_tx_scheduler
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference (pending bits, a queue for keyboard events, a streak count) is
//   advanced on every rising edge and compared with the outputs 1 ns later.
// -----------------------------------------------------------------------------
module tb_mon_tx_scheduler;

    localparam int          KBD_DEPTH  = 4;
    localparam int          MAX_STREAK = 3;
    localparam logic [39:0] PWR_CODE   = 40'hC000000000;
    localparam logic [39:0] AUD_CODE   = 40'hC700000000;

    logic        mon_clk = 1'b0;
    logic        rst_n;
    logic        power_on_req;
    logic        audio_req;
    logic        kbd_valid;
    logic        kbd_is_mouse;
    logic [15:0] kbd_data;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [39:0] pkt_data;
    logic        kbd_overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit          m_pend_pwr;
    bit          m_pend_aud;
    bit          m_valid;
    bit          m_ovf;
    logic [39:0] m_data;
    int          m_win;       // 0 power, 1 audio, 2 keyboard
    logic [16:0] m_q[$];
    int          m_streak;
    logic [7:0]  m_drop;

    logic [39:0] got[$];

    mon_tx_scheduler dut (
        .mon_clk      (mon_clk),
        .rst_n        (rst_n),
        .power_on_req (power_on_req),
        .audio_req    (audio_req),
        .kbd_valid    (kbd_valid),
        .kbd_is_mouse (kbd_is_mouse),
        .kbd_data     (kbd_data),
        .pkt_ready    (pkt_ready),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .kbd_overflow (kbd_overflow),
        .drop_cnt     (drop_cnt)
    );

    always #5 mon_clk = ~mon_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] kbd_pkt(input logic [16:0] e);
        return {7'b1100010, e[16], 8'h00, e[15:0], 8'h00};
    endfunction

    task automatic model_reset();
        m_pend_pwr = 0;
        m_pend_aud = 0;
        m_valid    = 0;
        m_ovf      = 0;
        m_data     = '0;
        m_win      = 0;
        m_q.delete();
        m_streak   = 0;
        m_drop     = 8'd0;
    endtask

    // One rising edge of the reference, using the inputs currently applied.
    task automatic model_edge();
        bit          grant;
        bit          q_empty;
        bit          acc;
        int          win;
        logic [39:0] pkt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        q_empty = (m_q.size() == 0);
        grant   = 0;
        win     = 0;
        pkt     = '0;
        if (!m_valid) begin
            if (m_pend_pwr) begin
                grant = 1; win = 0; pkt = PWR_CODE;
            end else if (m_pend_aud && !(m_streak == MAX_STREAK && !q_empty)) begin
                grant = 1; win = 1; pkt = AUD_CODE;
            end else if (!q_empty) begin
                grant = 1; win = 2; pkt = kbd_pkt(m_q[0]);
            end
        end
        acc = m_valid && pkt_ready;
        if (acc) begin
            if (m_win == 0) m_pend_pwr = 0;
            else if (m_win == 1) m_pend_aud = 0;
            else m_q.delete(0);
        end
        if (power_on_req) m_pend_pwr = 1;
        if (audio_req) m_pend_aud = 1;
        m_ovf = 0;
        if (kbd_valid) begin
            if (m_q.size() < KBD_DEPTH) begin
                m_q.push_back({kbd_is_mouse, kbd_data});
            end else begin
                m_ovf = 1;
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end
        end
        if (q_empty || (grant && win == 2)) m_streak = 0;
        else if (grant && win == 1 && m_streak < MAX_STREAK) m_streak++;
        if (acc) begin
            m_valid = 0;
        end else if (grant) begin
            m_valid = 1;
            m_data  = pkt;
            m_win   = win;
        end
    endtask

    task automatic compare_model();
        check("pkt_valid", 64'(pkt_valid), 64'(m_valid));
        if (m_valid) check("pkt_data", 64'(pkt_data), 64'(m_data));
        check("kbd_overflow", 64'(kbd_overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic tick();
        @(posedge mon_clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic clear_inputs();
        power_on_req = 0;
        audio_req    = 0;
        kbd_valid    = 0;
        kbd_is_mouse = 0;
        kbd_data     = '0;
    endtask

    // Ticks up to n times, recording each packet that is accepted on the next edge.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (pkt_valid && pkt_ready) got.push_back(pkt_data);
            tick();
        end
    endtask

    function automatic int count_code(input logic [39:0] code);
        int c = 0;
        foreach (got[i]) if (got[i] == code) c++;
        return c;
    endfunction

    initial begin
        int ovf_seen;
        logic [39:0] exp_seq[$];

        rst_n = 0;
        clear_inputs();
        pkt_ready = 0;
        model_reset();
        #12;
        check("reset_valid", 64'(pkt_valid), 64'd0);
        check("reset_data", 64'(pkt_data), 64'd0);
        check("reset_ovf", 64'(kbd_overflow), 64'd0);
        check("reset_drop", 64'(drop_cnt), 64'd0);
        @(posedge mon_clk);
        #1;
        rst_n = 1;
        tick();

        // Single keyboard event: offered two edges after the push, held until ready.
        kbd_valid = 1; kbd_is_mouse = 0; kbd_data = 16'h1234;
        tick();
        clear_inputs();
        check("kbd_first_edge_valid", 64'(pkt_valid), 64'd0);
        tick();
        check("kbd_second_edge_valid", 64'(pkt_valid), 64'd1);
        check("kbd_pkt_data", 64'(pkt_data), 64'hC400123400);
        repeat (4) tick();
        check("kbd_hold_data", 64'(pkt_data), 64'hC400123400);
        pkt_ready = 1;
        tick();
        pkt_ready = 0;
        check("kbd_after_accept", 64'(pkt_valid), 64'd0);
        tick();

        // Simultaneous events drain in priority order.
        power_on_req = 1; audio_req = 1;
        kbd_valid = 1; kbd_is_mouse = 1; kbd_data = 16'hBEEF;
        pkt_ready = 1;
        got.delete();
        collect(1);
        clear_inputs();
        collect(15);
        check("order_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            check("order_0", 64'(got[0]), 64'(PWR_CODE));
            check("order_1", 64'(got[1]), 64'(AUD_CODE));
            check("order_2", 64'(got[2]), 64'hC500BEEF00);
        end
        pkt_ready = 0;
        tick();

        // Five pushes into a four-entry FIFO with the Sender stalled.
        ovf_seen = 0;
        for (int i = 0; i < 5; i++) begin
            kbd_valid = 1; kbd_is_mouse = 1'(i); kbd_data = 16'h0A00 + 16'(i);
            tick();
            if (kbd_overflow) ovf_seen++;
        end
        clear_inputs();
        repeat (2) begin
            tick();
            if (kbd_overflow) ovf_seen++;
        end
        check("overflow_pulses", 64'(ovf_seen), 64'd1);
        check("drop_cnt_one", 64'(drop_cnt), 64'd1);
        got.delete();
        pkt_ready = 1;
        collect(12);
        check("drain_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) check("drain_entry", 64'(got[i]), 64'(kbd_pkt({1'(i), 16'h0A00 + 16'(i)})));
        end
        pkt_ready = 0;

        // Continuous audio with keyboard waiting: three audio grants, then one keyboard.
        for (int i = 0; i < 4; i++) begin
            kbd_valid = 1; kbd_is_mouse = 0; kbd_data = 16'h5000 + 16'(i);
            tick();
        end
        clear_inputs();
        repeat (2) tick();
        audio_req = 1;
        pkt_ready = 1;
        got.delete();
        for (int i = 0; i < 40 && got.size() < 9; i++) collect(1);
        audio_req = 0;
        exp_seq = '{kbd_pkt({1'b0, 16'h5000}), AUD_CODE, AUD_CODE, AUD_CODE,
                    kbd_pkt({1'b0, 16'h5001}), AUD_CODE, AUD_CODE, AUD_CODE,
                    kbd_pkt({1'b0, 16'h5002})};
        check("streak_count", 64'(got.size()), 64'd9);
        foreach (exp_seq[i]) begin
            if (i < got.size()) check("streak_seq", 64'(got[i]), 64'(exp_seq[i]));
        end
        collect(30);
        pkt_ready = 0;
        tick();

        // Audio request on the accept edge yields a second packet; duplicates merge.
        audio_req = 1;
        tick();
        audio_req = 0;
        tick();
        audio_req = 1;
        repeat (2) tick();
        audio_req = 0;
        check("aud_offer_valid", 64'(pkt_valid), 64'd1);
        check("aud_offer_data", 64'(pkt_data), 64'(AUD_CODE));
        pkt_ready = 1; audio_req = 1;
        tick();
        audio_req = 0;
        got.delete();
        collect(10);
        check("aud_rearm_count", 64'(count_code(AUD_CODE)), 64'd1);
        pkt_ready = 0;
        repeat (3) begin
            audio_req = 1;
            tick();
        end
        audio_req = 0;
        repeat (2) tick();
        pkt_ready = 1;
        got.delete();
        collect(10);
        check("aud_merge_count", 64'(count_code(AUD_CODE)), 64'd1);
        pkt_ready = 0;

        // Asynchronous reset while a packet is offered.
        power_on_req = 1;
        tick();
        power_on_req = 0;
        tick();
        check("pre_reset_valid", 64'(pkt_valid), 64'd1);
        check("pre_reset_drop", 64'(drop_cnt), 64'd1);
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check("async_reset_valid", 64'(pkt_valid), 64'd0);
        check("async_reset_drop", 64'(drop_cnt), 64'd0);
        check("async_reset_data", 64'(pkt_data), 64'd0);
        repeat (2) tick();
        rst_n = 1;
        pkt_ready = 1;
        repeat (5) tick();
        check("post_reset_idle", 64'(pkt_valid), 64'd0);
        check("post_reset_drop", 64'(drop_cnt), 64'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 500; i++) begin
            power_on_req = ($urandom_range(15) == 0);
            audio_req    = ($urandom_range(3) == 0);
            kbd_valid    = ($urandom_range(2) == 0);
            kbd_is_mouse = 1'($urandom_range(1));
            kbd_data     = 16'($urandom());
            pkt_ready    = ($urandom_range(2) != 0) || (i % 97 < 5 ? 1'b0 : 1'b0);
            tick();
        end
        clear_inputs();
        pkt_ready = 1;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
